// File: rtl/trigger_engine.sv
// Acquisition trigger: edge/level crossing detect with hysteresis, glitch
// confirmation, holdoff and single/normal/auto modes; latches crossing address.
module trigger_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int CONF_WIDTH = 8,
  parameter int TMO_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  arm,
  input  logic                  disarm,
  input  logic [DATA_WIDTH-1:0] cfg_level,
  input  logic [DATA_WIDTH-1:0] cfg_hyst,
  input  logic [1:0]            cfg_edge,
  input  logic                  cfg_signed,
  input  logic [1:0]            cfg_mode,
  input  logic [CONF_WIDTH-1:0] cfg_confirm,
  input  logic [CONF_WIDTH-1:0] cfg_holdoff,
  input  logic [TMO_WIDTH-1:0]  cfg_timeout,
  output logic                  trig_pulse,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic                  trig_forced,
  output logic [15:0]           trig_count,
  output logic [2:0]            state,
  output logic                  armed
);

  // state    | meaning
  // IDLE     | inactive, waiting for arm
  // ARMING   | waiting for a sample on the pre-crossing side
  // READY    | waiting for a sample on the post-crossing side
  // CONFIRM  | counting post/band samples before accepting the crossing
  // TRIG     | one-cycle trigger strobe
  // HOLDOFF  | ignoring valid samples after a trigger
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMING  = 3'd1,
    S_READY   = 3'd2,
    S_CONFIRM = 3'd3,
    S_TRIG    = 3'd4,
    S_HOLDOFF = 3'd5
  } state_t;

  localparam logic [CONF_WIDTH-1:0] CONF_ONE = 1;
  localparam logic [TMO_WIDTH-1:0]  TMO_ONE  = 1;

  state_t                  state_q, state_n;
  logic [DATA_WIDTH-1:0]   level_s, hyst_s;
  logic [1:0]              edge_s, mode_s;
  logic                    signed_s;
  logic [CONF_WIDTH-1:0]   confirm_s, holdoff_s;
  logic [TMO_WIDTH-1:0]    timeout_s;

  logic                    s1_valid;
  logic [DATA_WIDTH-1:0]   s1_data;
  logic [ADDR_WIDTH-1:0]   s1_addr;

  logic [CONF_WIDTH-1:0]   cnt_q, cnt_n;
  logic [TMO_WIDTH-1:0]    tmo_q, tmo_n;
  logic [ADDR_WIDTH-1:0]   cand_q, cand_n;
  logic                    pre_below_q, pre_below_n;
  logic                    go_trig, forced_n;
  logic [ADDR_WIDTH-1:0]   trig_addr_n;

  logic [DATA_WIDTH-1:0]   sign_mask, hi, lo;
  logic                    above, below, pre_hit, post_hit;
  logic                    edge_either, mode_single, mode_auto;
  logic                    tmo_hit, holdoff_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      level_s   <= '0;
      hyst_s    <= '0;
      edge_s    <= '0;
      mode_s    <= '0;
      signed_s  <= 1'b0;
      confirm_s <= '0;
      holdoff_s <= '0;
      timeout_s <= '0;
    end else if (arm && !disarm) begin
      level_s   <= cfg_level;
      hyst_s    <= cfg_hyst;
      edge_s    <= cfg_edge;
      mode_s    <= cfg_mode;
      signed_s  <= cfg_signed;
      confirm_s <= cfg_confirm;
      holdoff_s <= cfg_holdoff;
      timeout_s <= cfg_timeout;
    end
  end

  // Flipping the MSB turns two's complement into offset binary so all
  // threshold compares can be unsigned.
  assign sign_mask = {signed_s, {(DATA_WIDTH-1){1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data ^ sign_mask;
        s1_addr <= in_addr;
      end
    end
  end

  assign hi          = level_s ^ sign_mask;
  assign lo          = (hi >= hyst_s) ? (hi - hyst_s) : '0;
  assign above       = s1_valid && (s1_data >= hi);
  assign below       = s1_valid && (s1_data < lo);
  assign pre_hit     = pre_below_q ? below : above;
  assign post_hit    = pre_below_q ? above : below;
  assign edge_either = (edge_s == 2'b10);
  assign mode_single = (mode_s == 2'b00);
  assign mode_auto   = (mode_s == 2'b10);
  // Fires on the cycle the timer would reach cfg_timeout, so TRIG follows
  // exactly cfg_timeout clocks spent in ARMING/READY.
  assign tmo_hit      = mode_auto && (timeout_s != '0) && ((tmo_q + TMO_ONE) == timeout_s);
  assign holdoff_done = (holdoff_s == '0) || (s1_valid && ((cnt_q + CONF_ONE) == holdoff_s));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      cand_q      <= '0;
      pre_below_q <= 1'b1;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      tmo_q       <= tmo_n;
      cand_q      <= cand_n;
      pre_below_q <= pre_below_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    tmo_n       = tmo_q;
    cand_n      = cand_q;
    pre_below_n = pre_below_q;
    go_trig     = 1'b0;
    forced_n    = 1'b0;
    trig_addr_n = cand_q;
    case (state_q)
      S_ARMING: begin
        if (tmo_hit) begin
          state_n     = S_TRIG;
          go_trig     = 1'b1;
          forced_n    = 1'b1;
          trig_addr_n = s1_addr;
          tmo_n       = '0;
        end else begin
          tmo_n = tmo_q + TMO_ONE;
          if (edge_either && (above || below)) begin
            pre_below_n = below;
            state_n     = S_READY;
          end else if (!edge_either && pre_hit) begin
            state_n = S_READY;
          end
        end
      end
      S_READY: begin
        if (post_hit) begin
          cand_n = s1_addr;
          tmo_n  = '0;
          if (confirm_s == '0) begin
            state_n     = S_TRIG;
            go_trig     = 1'b1;
            trig_addr_n = s1_addr;
          end else begin
            state_n = S_CONFIRM;
            cnt_n   = '0;
          end
        end else if (tmo_hit) begin
          state_n     = S_TRIG;
          go_trig     = 1'b1;
          forced_n    = 1'b1;
          trig_addr_n = s1_addr;
          tmo_n       = '0;
        end else begin
          tmo_n = tmo_q + TMO_ONE;
        end
      end
      S_CONFIRM: begin
        if (pre_hit) begin
          state_n = S_READY;
          cnt_n   = '0;
        end else if (s1_valid) begin
          if ((cnt_q + CONF_ONE) == confirm_s) begin
            state_n     = S_TRIG;
            go_trig     = 1'b1;
            trig_addr_n = cand_q;
          end else begin
            cnt_n = cnt_q + CONF_ONE;
          end
        end
      end
      S_TRIG: begin
        state_n = S_HOLDOFF;
        cnt_n   = '0;
        tmo_n   = '0;
      end
      S_HOLDOFF: begin
        if (holdoff_done) begin
          state_n = mode_single ? S_IDLE : S_ARMING;
          cnt_n   = '0;
          tmo_n   = '0;
        end else if (s1_valid) begin
          cnt_n = cnt_q + CONF_ONE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (disarm) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      tmo_n   = '0;
      go_trig = 1'b0;
    end else if (arm) begin
      state_n     = S_ARMING;
      cnt_n       = '0;
      tmo_n       = '0;
      pre_below_n = (cfg_edge != 2'b01);
      go_trig     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_pulse  <= 1'b0;
      trig_addr   <= '0;
      trig_forced <= 1'b0;
      trig_count  <= '0;
    end else begin
      trig_pulse <= go_trig;
      if (go_trig) begin
        trig_addr   <= trig_addr_n;
        trig_forced <= forced_n;
        trig_count  <= trig_count + 16'd1;
      end
    end
  end

  assign state = state_q;
  assign armed = (state_q == S_ARMING) || (state_q == S_READY) || (state_q == S_CONFIRM);

endmodule
